alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer that drives an external combinational ALU. It iterates shifts
// one bit per cycle, keeps an accumulator for chaining, and holds each result until it is consumed.
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [4:0]       cmd_cnt,
  input  logic             cmd_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHR  = 4'b0110;
  localparam logic [3:0] OP_NONE = 4'b1111;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [3:0]       op_r;
  logic [4:0]       cnt_r;
  logic             accept_s;

  // Command handshake: only the idle state accepts.
  always_comb begin
    accept_s = cmd_valid && (state_r == ST_IDLE);
  end

  // Next-state decode; a shift leaves EXEC on the edge that consumes its last bit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (is_shift(cmd_op) && (cmd_cnt == 5'd0)) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_EXEC;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (is_shift(op_r) && (cnt_r > 5'd1)) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: command latch, iterative work value, accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_r <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      acc_r  <= {WIDTH{1'b0}};
      op_r   <= OP_NONE;
      cnt_r  <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r   <= cmd_op;
            b_r    <= cmd_b;
            cnt_r  <= cmd_cnt;
            work_r <= cmd_acc ? acc_r : cmd_a;
          end
        end
        ST_EXEC: begin
          work_r <= alu_out;
          if (is_shift(op_r)) begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            acc_r <= work_r;
          end
        end
        default: begin
          work_r <= work_r;
        end
      endcase
    end
  end

  // Output decode from registered state; the ALU sees a neutral opcode when not executing.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = {WIDTH{1'b0}};
    alu_a     = {WIDTH{1'b0}};
    alu_b     = {WIDTH{1'b0}};
    alu_op    = OP_NONE;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = 1'b1;
      end
      ST_EXEC: begin
        alu_a  = work_r;
        alu_b  = b_r;
        alu_op = op_r;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = work_r;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
    rsp_zero = (rsp_data == {WIDTH{1'b0}});
  end

endmodule
